// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - start/pattern request and serial output bundle for seq_pattern_tx
interface seq_pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
);
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic [GAP_W-1:0] gap;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, repeat_n, gap,
        input  x, valid, busy, done
    );

    modport slave (
        input  start, pattern, repeat_n, gap,
        output x, valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - MSB-first serial pattern transmitter with repeat count and inter-repeat gap
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    seq_pattern_tx_if.slave bus
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]    LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0]    ONE_B    = BW'(1);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [GAP_W-1:0] ONE_G    = GAP_W'(1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_q;     // captured pattern, reloaded at the start of every repetition
    logic [WIDTH-1:0] sr;        // bits still to send in this repetition, MSB aligned
    logic [BW-1:0]    bit_idx;   // index of the bit currently on x (0 = MSB)
    logic [CNT_W-1:0] rep_cnt;   // repetitions remaining after the current one
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_cnt;   // gap cycles remaining after the current one
    logic             x_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    assign bus.x     = x_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

    // Control FSM; outputs are computed for the state being entered so they stay registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_q   <= '0;
            sr      <= '0;
            bit_idx <= '0;
            rep_cnt <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    x_q     <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.repeat_n != '0) begin
                            pat_q   <= bus.pattern;
                            gap_q   <= bus.gap;
                            rep_cnt <= bus.repeat_n - ONE_C;
                            sr      <= bus.pattern << 1;
                            x_q     <= bus.pattern[WIDTH-1];
                            valid_q <= 1'b1;
                            bit_idx <= '0;
                            state   <= SEND;
                        end else begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                SEND: begin
                    if (bit_idx != LAST_BIT) begin
                        bit_idx <= bit_idx + ONE_B;
                        x_q     <= sr[WIDTH-1];
                        sr      <= sr << 1;
                    end else if (rep_cnt != '0) begin
                        rep_cnt <= rep_cnt - ONE_C;
                        if (gap_q != '0) begin
                            gap_cnt <= gap_q - ONE_G;
                            x_q     <= 1'b0;
                            valid_q <= 1'b0;
                            state   <= GAP;
                        end else begin
                            // back-to-back repetition: restart at the MSB with no idle cycle
                            bit_idx <= '0;
                            x_q     <= pat_q[WIDTH-1];
                            sr      <= pat_q << 1;
                        end
                    end else begin
                        x_q     <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state   <= DONE;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - ONE_G;
                    end else begin
                        bit_idx <= '0;
                        x_q     <= pat_q[WIDTH-1];
                        sr      <= pat_q << 1;
                        valid_q <= 1'b1;
                        state   <= SEND;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the driving end of the serial-bit interface consumed by the team's sequence detectors (e.g. the 1011 detector). On a start handshake it captures a WIDTH-bit pattern and emits it MSB-first, one bit per clock, on `x`. It repeats the pattern a programmable number of times with a programmable gap of zero bits between repetitions, then pulses `done`. It serves as the stimulus source for detector verification and as the serial TX stage in loop-back builds.

## Interface

Parameters:
- WIDTH, 4, pattern length in bits (≥2)
- CNT_W, 4, width of repeat count
- GAP_W, 4, width of gap count

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset; one clock, sampled on rising edge of clk
- start  input  1  request; accepted only when in IDLE
- pattern  input  WIDTH  bits to send, MSB first; captured on accepted start
- repeat_n  input  CNT_W  number of pattern transmissions; captured on accepted start
- gap  input  GAP_W  zero-bit cycles inserted between repetitions; captured on accepted start
- x  output  1  serial data, registered
- valid  output  1  high when `x` carries a pattern bit
- busy  output  1  high from acceptance through the DONE cycle
- done  output  1  one-cycle completion pulse

## Operation

- FSM states: IDLE, SEND, GAP, DONE.
- IDLE: x=0, valid=0, busy=0, done=0.
  - start=1 and repeat_n≠0: capture pattern/repeat_n/gap into shadow registers; go to SEND.
  - start=1 and repeat_n=0: go directly to DONE; no bits are sent.
- SEND: x=shadow pattern bit [WIDTH-1-bit_idx], valid=1, busy=1.
  - bit_idx increments each cycle.
  - After bit 0, if repetitions remain:
    - gap≠0: go to GAP.
    - gap=0: reload bit_idx and continue in SEND (back-to-back; no idle cycle).
  - After bit 0 of the last repetition: go to DONE.
- GAP: x=0, valid=0, busy=1 for exactly `gap` cycles, then return to SEND at the MSB.
- DONE: done=1, busy=1, x=0, valid=0 for one cycle, then IDLE.
- start while not in IDLE (including the DONE cycle) is ignored.
- Changes to pattern/repeat_n/gap inputs after acceptance have no effect.
- Counters:
  - bit counter: ceil(log2 WIDTH) bits.
  - repeat counter: CNT_W bits, counts down; no wrap.
  - gap counter: GAP_W bits, counts down.
- Reset (any state, including mid-pattern): next edge forces IDLE, all outputs 0, and clears counters and shadow registers. A start sampled on the same edge as rst=1 is discarded.

## Timing

- Cycle numbering: "cycle n" is the period after the n-th rising edge, where edge 1 is the acceptance edge.
- Pattern bit k (k=0 is the MSB) of repetition r (r=0..R-1) appears on `x` in cycle 1 + r·(WIDTH+gap) + k.
- `done` is high in exactly cycle R·WIDTH + (R−1)·gap + 1.
- `busy` is high from cycle 1 through the done cycle inclusive.
- The earliest next accepted start is the edge ending the done cycle + 1, i.e. start sampled while in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: x=0, valid=0, busy=0, done=0.

## Test plan

1. Reset: hold rst=1 for 2 cycles with start=1 → x=valid=busy=done=0, no transmission after release.
2. pattern=1011, repeat_n=1, gap=0 → x=1,0,1,1 in cycles 1–4; valid=1 in cycles 1–4; done=1 only in cycle 5; busy in cycles 1–5; drive the 1011 detector from x → z asserts once.
3. pattern=1011, repeat_n=3, gap=2 → x stream 1011 00 1011 00 1011; valid low during both gaps; done in cycle 17. Repeat with gap=0 → stream 101110111011, done in cycle 13; detector z fires 3 times.
4. start re-asserted and pattern changed to 0000 in cycle 2 of a 1011 send → ignored; stream unchanged; a start asserted in the done cycle is also ignored.
5. rst=1 sampled in cycle 3 of a repeat_n=2 send → from the next cycle x=valid=busy=done=0, FSM in IDLE; a new start then transmits correctly from the MSB.
6. repeat_n=0 → valid never asserts, x=0, done=1 and busy=1 in cycle 1 only.
